// File: rtl/status_pkg.sv
// status_pkg: shared sizes, FSM states and helpers for the status update scheduler.
package status_pkg;
    localparam int N = 10;
    localparam int W = 4;
    localparam int IW = 4;
    localparam int MAXV = 9;
    localparam int INIT = 1;
    localparam int BEEP_CYC_DEF = 50000000;
    localparam logic [N:0] ONE_M = 1;

    typedef enum logic [1:0] {ST_IDLE, ST_UPDATE, ST_INIT} state_t;

    function automatic logic [N-1:0] active_mask(input logic [2:0] count);
        int c;
        logic [N:0] m;
        c = (count > 3'd5) ? 5 : int'(count);
        m = (ONE_M << (2 * c)) - ONE_M;
        return m[N-1:0];
    endfunction

    // Anything at or above MAXV wraps, so corrupted nibbles self-heal.
    function automatic logic [W-1:0] bump(input logic [W-1:0] v);
        return (v >= W'(MAXV)) ? '0 : v + 1'b1;
    endfunction
endpackage

// File: rtl/status_update_sched_if.sv
// status_update_sched_if: control inputs and counter-file outputs of the scheduler.
interface status_update_sched_if;
    import status_pkg::*;
    logic           enable;
    logic [2:0]     count;
    logic           init;
    logic [N-1:0]   req;
    logic [N*W-1:0] status_out;
    logic           wr_en;
    logic [IW-1:0]  wr_index;
    logic [W-1:0]   wr_value;
    logic           beep;
    logic           busy;

    modport master (
        output enable, count, init, req,
        input  status_out, wr_en, wr_index, wr_value, beep, busy
    );
    modport slave (
        input  enable, count, init, req,
        output status_out, wr_en, wr_index, wr_value, beep, busy
    );
endinterface

// File: rtl/status_rr_pick.sv
// status_rr_pick: combinational round-robin picker, first set bit at or after i_ptr, wrapping.
module status_rr_pick
    import status_pkg::*;
(
    input  logic [N-1:0]  i_req,
    input  logic [IW-1:0] i_ptr,
    output logic          o_valid,
    output logic [IW-1:0] o_sel
);
    logic [IW-1:0] w_j;

    // Scan farthest-first so the candidate nearest the pointer is assigned last.
    always_comb begin
        o_sel = '0;
        w_j = '0;
        for (int k = N - 1; k >= 0; k--) begin
            w_j = IW'((int'(i_ptr) + k) % N);
            if (i_req[w_j]) o_sel = w_j;
        end
        o_valid = |i_req;
    end
endmodule

// File: rtl/status_update_sched.sv
// status_update_sched: captures button edges, grants one round-robin counter update at a time,
// runs the initialise-all sweep and times the wrap beep.
module status_update_sched
    import status_pkg::*;
#(
    parameter int BEEP_CYC = BEEP_CYC_DEF
) (
    input logic clk,
    input logic rst,
    status_update_sched_if.slave bus
);
    state_t         r_state, w_state_nx;
    logic [N*W-1:0] r_status;
    logic [N-1:0]   r_pending, r_req_q, w_mask, w_rise, w_clear;
    logic [IW-1:0]  r_rr_ptr, r_sel, w_sel_nx, r_idx, w_idx_nx, w_pick, w_widx;
    logic           w_valid, w_we, w_wrap;
    logic [W-1:0]   w_cur, w_wval;
    logic           r_wr_en;
    logic [IW-1:0]  r_wr_index;
    logic [W-1:0]   r_wr_value;
    logic [31:0]    r_beep_cnt;

    assign w_mask = active_mask(bus.count);
    assign w_rise = bus.req & ~r_req_q & w_mask;
    assign w_cur  = r_status[int'(r_sel)*W +: W];
    assign w_wrap = w_cur >= W'(MAXV);

    status_rr_pick u_pick (
        .i_req   (r_pending & w_mask),
        .i_ptr   (r_rr_ptr),
        .o_valid (w_valid),
        .o_sel   (w_pick)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_sel   <= '0;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_nx;
            r_sel   <= w_sel_nx;
            r_idx   <= w_idx_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        w_sel_nx   = r_sel;
        w_idx_nx   = r_idx;
        w_we       = 1'b0;
        w_widx     = r_sel;
        w_wval     = bump(w_cur);
        w_clear    = '0;
        case (r_state)
            ST_IDLE: begin
                if (bus.init) begin
                    w_state_nx = ST_INIT;
                    w_idx_nx   = '0;
                end else if (bus.enable && w_valid) begin
                    w_state_nx = ST_UPDATE;
                    w_sel_nx   = w_pick;
                end
            end
            ST_UPDATE: begin
                w_we           = 1'b1;
                w_clear[r_sel] = 1'b1;
                w_state_nx     = bus.init ? ST_INIT : ST_IDLE;
                w_idx_nx       = '0;
            end
            ST_INIT: begin
                w_we       = 1'b1;
                w_widx     = r_idx;
                w_wval     = W'(INIT);
                w_idx_nx   = bus.init ? '0 : r_idx + 1'b1;
                w_state_nx = (!bus.init && r_idx == IW'(N - 1)) ? ST_IDLE : ST_INIT;
            end
            default: w_state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_status   <= {N{W'(INIT)}};
            r_pending  <= '0;
            r_req_q    <= '0;
            r_rr_ptr   <= '0;
            r_wr_en    <= 1'b0;
            r_wr_index <= '0;
            r_wr_value <= '0;
            r_beep_cnt <= '0;
        end else begin
            r_req_q    <= bus.req;
            r_pending  <= (bus.init || r_state == ST_INIT) ? '0 : (r_pending & ~w_clear) | w_rise;
            r_wr_en    <= w_we;
            if (w_we) begin
                r_status[int'(w_widx)*W +: W] <= w_wval;
                r_wr_index <= w_widx;
                r_wr_value <= w_wval;
            end
            if (r_state == ST_UPDATE) r_rr_ptr <= (r_sel == IW'(N - 1)) ? '0 : r_sel + 1'b1;
            else if (r_state == ST_INIT) r_rr_ptr <= '0;
            r_beep_cnt <= (r_state == ST_UPDATE && w_wrap) ? 32'(BEEP_CYC) :
                          (r_beep_cnt != 0) ? r_beep_cnt - 1'b1 : '0;
        end
    end

    assign bus.status_out = r_status;
    assign bus.wr_en      = r_wr_en;
    assign bus.wr_index   = r_wr_index;
    assign bus.wr_value   = r_wr_value;
    assign bus.beep       = r_beep_cnt != 0;
    assign bus.busy       = r_state != ST_IDLE;
endmodule

// File: doc/status_update_sched.md
Name: status_update_sched

Overview:
Sequencer and arbiter for the shared per-object counter register file: up to N objects, each a W-bit wrap-at-9 counter. Takes debounced button levels, detects rising edges and queues them as pending requests. Grants one request per update using round-robin, performs the read-modify-write on the granted nibble, and raises a timed beep event on every 9->0 wrap. Also sequences the "initialise all" sweep. Sits between the debounce/count-select logic and the counter storage, buzzer and display consumers.

Parameters:
N, 10, number of objects (counter nibbles)
W, 4, counter width in bits
MAXV, 9, last value before wrap to 0
INIT, 1, value loaded into every counter by rst or the init sweep
BEEP_CYC, 50000000, beep pulse length in clk cycles (1 s at 50 MHz)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
enable  in  1  grants allowed when high
count  in  3  active-group select; active objects = 2*count (0 = none, >5 clamped to 5)
init  in  1  level; starts the initialise-all sweep
req  in  N  debounced button levels, bit i = object i
status_out  out  N*W  counter file, nibble i at [i*W +: W]
wr_en  out  1  one-cycle strobe, a nibble was written this edge
wr_index  out  4  index written
wr_value  out  W  value written
beep  out  1  buzzer request
busy  out  1  high in UPDATE or INIT states

Behaviour:
- Clock and reset: one clock clk; rst is synchronous, active-high.
- Values on rst:
  - every status_out nibble = INIT
  - pending = 0, req_q = 0, rr_ptr = 0
  - wr_en = 0, wr_index = 0, wr_value = 0
  - beep = 0, beep counter = 0, busy = 0
  - state = IDLE
- active_mask: low 2*min(count,5) bits set; all other bits clear.
- Edge capture, every cycle:
  - req_q <= req
  - rise = req & ~req_q & active_mask
  - pending <= (pending & ~clear) | rise
  - rise wins over clear on the same bit in the same cycle.
  - Rises on inactive bits are dropped.
  - Pending bits already set stay set when count later shrinks, but are masked from arbitration.
- FSM states: IDLE, UPDATE, INIT.
- IDLE:
  - If init: go to INIT.
  - Else if enable and (pending & active_mask) != 0:
    - sel = first set bit scanning from rr_ptr upward, wrapping at N-1 -> 0
    - register sel, go to UPDATE.
- UPDATE (exactly one cycle):
  - new = (status[sel] >= MAXV) ? 0 : status[sel] + 1. Out-of-range values are treated as a wrap.
  - status[sel] <= new; wr_en = 1; wr_index = sel; wr_value = new.
  - clear pending[sel].
  - rr_ptr <= (sel == N-1) ? 0 : sel + 1.
  - If wrapped: beep counter <= BEEP_CYC.
  - Go to IDLE, or to INIT if init is high.
- Latency: a rise sampled at edge t sets pending at t+1. The grant is registered at t+2. The write is visible on status_out after edge t+3. Worst case to service all 10 pending: 20 cycles.
- enable low:
  - no new grants; pending is retained.
  - an UPDATE already in flight completes.
- INIT:
  - Entered from any state when init = 1. idx = 0; pending cleared; req edges ignored.
  - Each cycle: status[idx] <= INIT with a wr_en strobe; idx++.
  - After idx N-1: go to IDLE.
  - init still high re-arms idx = 0, so the sweep restarts.
  - rr_ptr is reset to 0; beep is unaffected.
- beep:
  - high while the beep counter != 0; the counter decrements each cycle.
  - A wrap during an active beep reloads the counter to BEEP_CYC.
- busy = (state != IDLE).

Decomposition:
- Shared package status_pkg holds N, W, MAXV, INIT, the FSM state enum and an active_mask function.
- Sub-module status_rr_pick: combinational round-robin picker.
  - Inputs: pending & active_mask, rr_ptr.
  - Outputs: valid, sel.
  - Keeps the wrap-scan logic separately testable.

Test Plan:
- rst, count=5, single pulse on req[3] held 4 cycles -> exactly one wr_en; wr_index=3; wr_value=2; status nibble3=2; others remain 1.
- req[0..9] all rise in the same cycle, rr_ptr=0 -> writes in index order 0,1,...,9, one every 2 cycles; 10 wr_en strobes total; rr_ptr ends at 0.
- Nibble 2 preset to 9 via eight prior presses, then press req[2] -> wr_value=0; beep high for exactly BEEP_CYC cycles (test with BEEP_CYC=8); second wrap mid-beep -> beep extended to 8 cycles from the second wrap.
- count=1, presses on req[5] and req[1] -> req[5] ignored (no write); req[1] serviced.
- Simultaneous/edge cases:
  - enable=0 while req[4] pressed -> no write, pending held.
  - enable raised -> write to 4 within 2 cycles.
  - rise on sel during its own UPDATE -> second write follows.
- init asserted 1 cycle during an UPDATE -> UPDATE completes; then 10 sweep writes of value 1 with indices 0..9; busy high for 10 cycles; presses during the sweep are dropped.
